// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: shared types and constants for the divided-clock edge monitor.
//   mon_state_t    - monitor FSM state encoding
//   cnt_sat_value  - all-ones saturation value of an unsigned counter of a given width
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2,
    LOCKED    = 2'd3
  } mon_state_t;

  // Widest period counter supported by cnt_sat_value.
  localparam int unsigned CNT_W_MAX = 31;

  function automatic logic [31:0] cnt_sat_value(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: multi-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk    in  sampling clock
//   reset  in  synchronous active-high reset, clears every stage to 0
//   d      in  asynchronous input
//   q      out synchronized output, STAGES clocks behind d
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clk_edge_monitor.sv
// clk_edge_monitor: receives a divided clock as data on clk, produces one-cycle
// rise/fall enables, measures the rise-to-rise period and reports lock/errors.
// Ports:
//   clk          in  system clock
//   reset        in  synchronous active-high reset
//   div_clk_in   in  divided clock, asynchronous to clk
//   en           in  monitor enable
//   err_clr      in  clears err_sticky (an error in the same cycle wins)
//   rise_pulse   out one-cycle strobe per synchronized rising edge
//   fall_pulse   out one-cycle strobe per synchronized falling edge
//   period       out last measured rise-to-rise period in clk cycles
//   period_valid out one-cycle strobe when period updates
//   locked       out period has matched DIV for LOCK_CNT consecutive periods
//   err_sticky   out period mismatch or timeout seen since last clear
//
// state     | meaning
// IDLE      | disabled; counter and lock cleared
// WAIT_EDGE | waiting for a reference rising edge
// MEASURE   | counting periods, collecting good periods toward lock
// LOCKED    | period stable at DIV; any bad period drops back to MEASURE
module clk_edge_monitor
  import clk_mon_pkg::*;
#(
  parameter int DIV         = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_clk_in,
  input  logic             en,
  input  logic             err_clr,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err_sticky
);

  localparam int              GOOD_W  = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(cnt_sat_value(CNT_W));
  localparam logic [CNT_W-1:0]  DIV_C   = CNT_W'(DIV);
  localparam logic [GOOD_W-1:0] LOCK_C  = GOOD_W'(LOCK_CNT);

  logic s, s_d, rise_q, fall_q;

  mon_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [GOOD_W-1:0] good, good_nxt, good_inc;
  logic [CNT_W-1:0]  period_nxt;
  logic              pv_nxt, locked_nxt, err_event;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (div_clk_in),
    .q     (s)
  );

  assign good_inc = good + GOOD_W'(1);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    good_nxt   = good;
    period_nxt = period;
    pv_nxt     = 1'b0;
    locked_nxt = locked;
    err_event  = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt    = '0;
        good_nxt   = '0;
        locked_nxt = 1'b0;
        state_nxt  = WAIT_EDGE;
      end
      WAIT_EDGE: begin
        // first edge only establishes a reference, no period is reported
        if (rise_q) begin
          cnt_nxt   = CNT_W'(1);
          state_nxt = MEASURE;
        end
      end
      MEASURE, LOCKED: begin
        if (rise_q) begin
          period_nxt = cnt;
          pv_nxt     = 1'b1;
          cnt_nxt    = CNT_W'(1);
          if (cnt == DIV_C) begin
            if (state == MEASURE) begin
              good_nxt = good_inc;
              if (good_inc == LOCK_C) begin
                state_nxt  = LOCKED;
                locked_nxt = 1'b1;
              end
            end
          end else begin
            good_nxt   = '0;
            err_event  = 1'b1;
            locked_nxt = 1'b0;
            state_nxt  = MEASURE;
          end
        end else if (cnt == CNT_MAX) begin
          // stuck input: counter holds at saturation, wait for a fresh reference
          err_event  = 1'b1;
          good_nxt   = '0;
          locked_nxt = 1'b0;
          state_nxt  = WAIT_EDGE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (!en) begin
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      good_nxt   = '0;
      period_nxt = period;
      pv_nxt     = 1'b0;
      locked_nxt = 1'b0;
      err_event  = 1'b0;
    end
  end

  // Edge detect is registered before the FSM consumes it; the strobe and
  // measurement outputs are registered again so all of them line up.
  // err_clr is sampled on the same edge that captures period_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_d          <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      state        <= IDLE;
      cnt          <= '0;
      good         <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err_sticky   <= 1'b0;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
    end else begin
      s_d          <= s;
      rise_q       <= s & ~s_d;
      fall_q       <= ~s & s_d;
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      good         <= good_nxt;
      period       <= period_nxt;
      period_valid <= pv_nxt;
      locked       <= locked_nxt;
      err_sticky   <= err_event | (err_sticky & ~err_clr);
      rise_pulse   <= en & rise_q;
      fall_pulse   <= en & fall_q;
    end
  end

endmodule

// File: tb/tb_clk_edge_monitor.sv
// tb_clk_edge_monitor: directed self-checking bench for clk_edge_monitor
// (DIV=4, CNT_W=8, SYNC_STAGES=2, LOCK_CNT=2).
module tb_clk_edge_monitor;
  import clk_mon_pkg::*;

  logic       clk = 1'b0;
  logic       reset, div_clk_in, en, err_clr;
  logic       rise_pulse, fall_pulse, period_valid, locked, err_sticky;
  logic [7:0] period;

  int n_checks = 0;
  int n_fail   = 0;

  // input generator: gen_half is the requested half period (0 = hold high),
  // applied at the next generated rising edge
  int gen_half  = 0;
  int act_half  = 0;
  int gen_cnt   = 0;
  int gen_rises = 0;

  clk_edge_monitor #(
    .DIV(4), .CNT_W(8), .SYNC_STAGES(2), .LOCK_CNT(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .div_clk_in   (div_clk_in),
    .en           (en),
    .err_clr      (err_clr),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .err_sticky   (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_pv(input string tag, output int cycles, output int rises);
    cycles = 0;
    rises  = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (period_valid !== 1'b1 && rise_pulse === 1'b1) rises++;
    end while (period_valid !== 1'b1 && cycles < 400);
    chk({tag, "_pv_seen"}, period_valid, 1);
  endtask

  task automatic wait_applied(input int h);
    int n = 0;
    while (act_half != h && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_rises(input int target);
    int n = 0;
    while (gen_rises < target && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    div_clk_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (act_half == 0) begin
        if (gen_half != 0) begin
          if (div_clk_in) begin
            div_clk_in = 1'b0;
          end else begin
            div_clk_in = 1'b1;
            act_half   = gen_half;
            gen_cnt    = 0;
            gen_rises++;
          end
        end
      end else begin
        gen_cnt++;
        if (gen_cnt >= act_half) begin
          gen_cnt    = 0;
          div_clk_in = ~div_clk_in;
          if (div_clk_in) begin
            gen_rises++;
            act_half = gen_half;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc, rises, n, r, lk, base;
    logic prev_in;

    reset   = 1'b1;
    en      = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {rise_pulse, fall_pulse, period_valid, locked, err_sticky, period}, 0);
    chk("rst_state", dut.state, IDLE);
    reset = 1'b0;
    en    = 1'b1;
    repeat (3) @(negedge clk);
    chk("en_wait_edge", dut.state, WAIT_EDGE);

    // latency: input rises just after the next posedge, strobe 4 negedges later
    gen_half = 2;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("rise_lat_k%0d", k), rise_pulse, (k == 5));
    end
    chk("first_rise_no_pv", period_valid, 0);
    for (int k = 6; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("fall_lat_k%0d", k), fall_pulse, (k == 7));
    end

    // acquire lock at DIV=4
    wait_pv("pv1", cyc, rises);
    chk("pv1_period", period, 4);
    chk("pv1_locked", locked, 0);
    chk("pv1_rise_coincident", rise_pulse, 1);
    wait_pv("pv2", cyc, rises);
    chk("pv2_spacing", cyc, 4);
    chk("pv2_period", period, 4);
    chk("pv2_locked", locked, 1);
    chk("pv2_err", err_sticky, 0);
    @(negedge clk);
    chk("strobe_width", {rise_pulse, period_valid}, 0);

    // switch to period 6; err_clr sampled on the same edge as the bad period_valid
    gen_half = 3;
    wait_applied(3);
    base = gen_rises;
    wait_pv("pre_switch", cyc, rises);
    chk("pre_switch_period", period, 4);
    chk("pre_switch_locked", locked, 1);
    wait_rises(base + 1);
    repeat (3) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("mis_pv", period_valid, 1);
    chk("mis_period", period, 6);
    chk("mis_locked", locked, 0);
    chk("mis_err_set_wins", err_sticky, 1);
    @(negedge clk);
    chk("mis_err_hold", err_sticky, 1);

    // back to period 4: relock after two good periods, err stays set
    gen_half = 2;
    wait_applied(2);
    wait_pv("back0", cyc, rises);
    chk("back0_period", period, 6);
    wait_pv("back1", cyc, rises);
    chk("back1_period", period, 4);
    chk("back1_locked", locked, 0);
    wait_pv("back2", cyc, rises);
    chk("back2_locked", locked, 1);
    chk("back2_err_sticky", err_sticky, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr_clears", err_sticky, 0);

    // hold input high: timeout 255 cycles after the last period
    gen_half = 0;
    wait_applied(0);
    wait_pv("hold_last", cyc, rises);
    chk("hold_last_locked", locked, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (locked === 1'b1 && n < 300);
    chk("timeout_cycles", n, 255);
    chk("timeout_err", err_sticky, 1);
    chk("timeout_state", dut.state, WAIT_EDGE);
    chk("timeout_period_hold", period, 4);

    // restart: first rise is a reference only
    gen_half = 2;
    wait_applied(2);
    wait_pv("restart", cyc, rises);
    chk("restart_ref_rises", rises, 1);
    chk("restart_period", period, 4);
    chk("restart_locked", locked, 0);
    wait_pv("restart2", cyc, rises);
    chk("restart2_locked", locked, 1);

    // disable for 10 cycles
    @(negedge clk);
    en = 1'b0;
    n  = 0;
    lk = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rise_pulse || fall_pulse || period_valid) n++;
      if (locked) lk++;
    end
    chk("dis_strobes", n, 0);
    chk("dis_locked_cycles", lk, 0);
    en = 1'b1;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rise_pulse !== 1'b1 && n < 20);
    chk("reen_rise_seen", rise_pulse, 1);
    chk("reen_first_rise_no_pv", period_valid, 0);
    wait_pv("reen1", cyc, rises);
    chk("reen1_period", period, 4);
    chk("reen1_locked", locked, 0);
    wait_pv("reen2", cyc, rises);
    chk("reen2_locked", locked, 1);

    // one-cycle reset while locked, aligned just after an input fall
    prev_in = div_clk_in;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      r = (prev_in === 1'b1 && div_clk_in === 1'b0) ? 1 : 0;
      prev_in = div_clk_in;
    end while (r == 0 && n < 20);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_outputs", {rise_pulse, fall_pulse, period_valid, locked, err_sticky, period}, 0);
    reset = 1'b0;
    n = 0;
    r = 0;
    do begin
      @(negedge clk);
      n++;
      if (rise_pulse === 1'b1) r++;
    end while (locked !== 1'b1 && n < 60);
    chk("relock_rises", r, 3);
    chk("relock_err", err_sticky, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_edge_monitor.md
# clk_edge_monitor

Fast-domain receiver for divided clocks such as the divide-by-4 clock output. It samples a slow clock as data on `clk`, synchronizes it, emits one-cycle rise/fall strobes for use as clock enables, and measures the slow period in `clk` cycles. It declares lock once the period matches the expected divide ratio, and flags deviations or a stuck input. It sits beside each clock divider, so control logic can run on `clk` with enables instead of on a derived clock.

## Interface
- `DIV`, default 4: expected slow period in `clk` cycles, rising edge to rising edge; must be ≥2.
- `CNT_W`, default 8: period counter width; requires `DIV` < 2^CNT_W − 1.
- `SYNC_STAGES`, default 2: synchronizer depth, ≥2.
- `LOCK_CNT`, default 2: consecutive good periods needed to assert `locked`.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `div_clk_in`  in  1  divided clock, treated as asynchronous data.
- `en`  in  1  monitor enable.
- `err_clr`  in  1  clears `err_sticky`.
- `rise_pulse`  out  1  one-cycle strobe per synchronized rising edge.
- `fall_pulse`  out  1  one-cycle strobe per synchronized falling edge.
- `period`  out  CNT_W  last measured rise-to-rise period.
- `period_valid`  out  1  one-cycle strobe when `period` updates.
- `locked`  out  1  period stable at `DIV`.
- `err_sticky`  out  1  mismatch or timeout seen since last clear.

## Operation
- Synchronizer: `div_clk_in` passes through `SYNC_STAGES` flops, giving `s`. A history flop `s_d` holds the previous `s`.
  - A rising edge is `s & ~s_d`; a falling edge is `~s & s_d`.
- Strobes are registered and gated by `en`. With `en`=0, the strobes are not generated. The synchronizer still runs, so re-enabling never produces a spurious edge.
- States: IDLE, WAIT_EDGE, MEASURE, LOCKED.
  - IDLE: entered on reset or when `en`=0. Counter = 0, `locked`=0. Goes to WAIT_EDGE when `en`=1.
  - WAIT_EDGE: on a rising edge, counter ← 1 and go to MEASURE. No `period` update, because the first edge has no reference.
  - MEASURE: counter increments each cycle. On a rising edge:
    - `period` ← counter and `period_valid` pulses; counter ← 1.
    - If counter == `DIV`, good-count++. When good-count reaches `LOCK_CNT`, go to LOCKED.
    - Otherwise good-count ← 0 and `err_sticky` is set.
  - LOCKED: same measurement as MEASURE. A mismatching period sets `err_sticky`, clears `locked`, resets good-count and returns to MEASURE.
- Timeout: if the counter reaches 2^CNT_W − 1 in MEASURE or LOCKED:
  - set `err_sticky`, clear `locked`, go to WAIT_EDGE;
  - the counter saturates and never wraps.
- Falling edges never affect measurement; they only drive `fall_pulse`.
- `err_clr` clears `err_sticky`. If an error event occurs in the same cycle, the set wins.
- Widths: the counter is CNT_W unsigned and the comparison with `DIV` is exact. Good-count width is clog2(`LOCK_CNT`+1).

## Timing
- Reset values: all outputs 0, including `period` = 0. The synchronizer flops and `s_d` are 0. State is IDLE.
- Reset mid-operation returns everything to reset values on the next edge; `err_sticky` is cleared too.
- Latency: a `div_clk_in` transition sampled at `clk` edge 0 produces `rise_pulse`/`fall_pulse` high during the cycle after edge `SYNC_STAGES`+1.
- `period_valid` is coincident with `rise_pulse`. `period` holds until the next update.
- `locked` rises in the cycle coincident with the `period_valid` of the `LOCK_CNT`-th good period. It falls coincident with the first bad `period_valid`, or on the cycle after timeout.
- Each strobe is exactly one cycle wide. The strobes for consecutive edges are at least 1 cycle apart, since `DIV` ≥ 2.
- The minimum slow high or low time is 1 `clk` cycle. Narrower pulses may be missed and are then reported as period errors.

## Structure
- Package `clk_mon_pkg`: the state enum (IDLE, WAIT_EDGE, MEASURE, LOCKED) and a constant for the counter saturation value.
- Sub-module `bit_synchronizer`: parameterized by `STAGES`, synchronous reset to 0. It is reused for other asynchronous inputs.
- Top level contains: edge detect, period counter, FSM, and error/lock logic.

## Test plan
- `DIV`=4: drive `div_clk_in` toggling every 2 `clk` cycles with `en`=1.
  - Required: `rise_pulse` every 4 cycles and `period`=4 on each `period_valid`.
  - Required: `locked`=1 at the second `period_valid`; `err_sticky` stays 0.
- After lock, switch the input to toggling every 3 cycles.
  - Required: the next `period`=6, `locked` drops with that `period_valid`, and `err_sticky`=1.
  - Switching back to every-2 toggling gives `locked`=1 again after 2 periods; `err_sticky` stays set until `err_clr`.
- After lock, hold `div_clk_in` at 1 (`CNT_W`=8).
  - Required: timeout at counter 255, `locked`=0, `err_sticky`=1, state WAIT_EDGE.
  - The next rise gives no `period_valid`; the following rise gives `period`=4.
- Assert `err_clr` in the same cycle as a mismatch `period_valid`. Required: `err_sticky`=1.
- Deassert `en` for 10 cycles while the input toggles.
  - Required: no strobes and `locked`=0.
  - On re-enable, the first rise gives no `period_valid`.
- Assert `reset` for 1 cycle while LOCKED. Required: all outputs 0 next cycle, with lock reacquired after `LOCK_CNT`+1 rises.
